fpu_ss_core_arbiter: RTL and testbench
======================================

FPU_SS_CORE_ARBITER -- requirements
Module: fpu_ss_core_arbiter

Interface
REQ-001 SHALL have parameter NB_CORES, default 8, meaning the number of requesting cores (2..16).
REQ-002 SHALL have parameter INSTR_W, default 32, meaning the instruction payload width per core.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the per-core in-flight credit limit (1..15).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  clock; all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 core_valid_i  in  NB_CORES  per-core issue request.
REQ-008 core_ready_o  out  NB_CORES  per-core issue accept.
REQ-009 core_instr_i  in  NB_CORES*INSTR_W  per-core instruction, core k at bits [k*INSTR_W +: INSTR_W].
REQ-010 fpu_valid_o  out  1  issue request to the shared fpu_ss.
REQ-011 fpu_ready_i  in  1  fpu_ss issue accept.
REQ-012 fpu_instr_o  out  INSTR_W  selected instruction.
REQ-013 fpu_core_id_o  out  32  index of the selected core, zero-extended.
REQ-014 res_valid_i  in  1  fpu_ss result valid.
REQ-015 res_ready_o  out  1  result accept toward fpu_ss.
REQ-016 res_core_id_i  in  32  destination core of the result.
REQ-017 core_res_valid_o  out  NB_CORES  one-hot routed result valid.
REQ-018 core_res_ready_i  in  NB_CORES  per-core result accept.
REQ-019 err_o  out  1  one-cycle pulse when a result is dropped for an invalid destination.

Function
REQ-020 Issue FSM SHALL have two states: IDLE (no grant held) and LOCKED (grant held, fpu_valid_o=1).
REQ-021 A core SHALL be eligible when core_valid_i[k]=1 and its credit counter cnt[k] < MAX_OUTSTANDING.
REQ-022 In IDLE with any eligible core, the arbiter SHALL pick the first eligible core at or after rr_ptr (wrapping NB_CORES-1 -> 0), drive fpu_valid_o=1 in the same cycle, and transition to IDLE on handshake or to LOCKED on no handshake.
REQ-023 In LOCKED, the selection, fpu_instr_o and fpu_core_id_o SHALL stay constant and fpu_valid_o SHALL stay 1 until fpu_ready_i=1; then the state SHALL return to IDLE.
REQ-024 core_ready_o[k] SHALL equal fpu_ready_i AND fpu_valid_o AND (granted core == k); all other bits SHALL be 0.
REQ-025 On an issue handshake with core g, rr_ptr SHALL become (g+1) mod NB_CORES; otherwise rr_ptr SHALL hold.
REQ-026 cnt[k] SHALL increment on an issue handshake of core k, decrement on a routed result handshake to core k, and hold when both occur in the same cycle.
REQ-027 cnt[k] SHALL never exceed MAX_OUTSTANDING; a result for core k with cnt[k]=0 SHALL be delivered and cnt[k] SHALL saturate at 0.
REQ-028 For res_core_id_i < NB_CORES: core_res_valid_o SHALL be the one-hot of res_core_id_i gated by res_valid_i, and res_ready_o SHALL equal core_res_ready_i[res_core_id_i]; result routing SHALL be combinational with zero latency.
REQ-029 For res_core_id_i >= NB_CORES with res_valid_i=1: res_ready_o SHALL be 1, core_res_valid_o SHALL be 0, no counter SHALL change, and err_o SHALL pulse high in the following cycle.
REQ-030 With no eligible core in IDLE, fpu_valid_o SHALL be 0; fpu_instr_o and fpu_core_id_o SHALL be 0.
REQ-031 A core dropping core_valid_i while LOCKED SHALL NOT cancel the grant; the latched instruction SHALL still be issued.

Reset
REQ-032 While rst_ni=0: state=IDLE, rr_ptr=0, all cnt=0, err_o=0, fpu_valid_o=0, core_ready_o=0, fpu_instr_o=0, fpu_core_id_o=0.
REQ-033 Reset asserted mid-LOCKED SHALL abandon the held grant immediately and asynchronously; no issue SHALL be replayed after reset release.
REQ-034 res_ready_o and core_res_valid_o SHALL remain combinational functions of their inputs during reset; counters SHALL not update.

Verification
REQ-035 Cores 0, 3, 5 valid continuously, fpu_ready_i=1 -> grants 0,3,5,0,3,5 on consecutive cycles, fpu_core_id_o matching.
REQ-036 Core 2 valid, fpu_ready_i=0 for 3 cycles, instr changed to 0xDEAD after cycle 1 -> fpu_instr_o holds the original value for 3 cycles, single handshake on cycle 4, cnt[2]=1.
REQ-037 Core 1 issues 4 times with no results (MAX_OUTSTANDING=4) -> 5th request not granted while core 4 is granted; after one result to core 1, cnt[1]=3 and core 1 is eligible again.
REQ-038 Issue handshake and result handshake for core 6 in the same cycle with cnt[6]=2 -> cnt[6] stays 2.
REQ-039 res_valid_i=1, res_core_id_i=9, NB_CORES=8 -> res_ready_o=1, core_res_valid_o=0, err_o=1 next cycle only.
REQ-040 rst_ni pulled low while LOCKED on core 7 -> fpu_valid_o=0 immediately; after release with no requests, fpu_valid_o stays 0 and rr_ptr=0.

Source files
------------

// File: rtl/fpu_ss_core_arbiter.sv
// fpu_ss_core_arbiter: shares a single fpu_ss issue port among NB_CORES cores.
// Round-robin issue arbitration with a grant lock held until the fpu_ss
// accepts. Per-core credit counters bound the number of in-flight
// instructions. Results are routed back combinationally by destination id.
module fpu_ss_core_arbiter #(
    parameter int NB_CORES        = 8,
    parameter int INSTR_W         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // core issue side
    input  logic [NB_CORES-1:0]           core_valid_i,
    output logic [NB_CORES-1:0]           core_ready_o,
    input  logic [NB_CORES*INSTR_W-1:0]   core_instr_i,
    // fpu_ss issue side
    output logic                          fpu_valid_o,
    input  logic                          fpu_ready_i,
    output logic [INSTR_W-1:0]            fpu_instr_o,
    output logic [31:0]                   fpu_core_id_o,
    // fpu_ss result side
    input  logic                          res_valid_i,
    output logic                          res_ready_o,
    input  logic [31:0]                   res_core_id_i,
    // core result side
    output logic [NB_CORES-1:0]           core_res_valid_o,
    input  logic [NB_CORES-1:0]           core_res_ready_i,
    output logic                          err_o
);

    localparam int PTR_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_id_q, gnt_id_d;
    logic [INSTR_W-1:0] gnt_instr_q, gnt_instr_d;
    logic [CNT_W-1:0]   cnt_q [NB_CORES];
    logic [CNT_W-1:0]   cnt_d [NB_CORES];
    logic               err_q;

    logic [NB_CORES-1:0] eligible;
    logic                pick_found;
    logic [PTR_W-1:0]    pick_id;
    logic [PTR_W-1:0]    cand;
    logic [INSTR_W-1:0]  pick_instr;

    logic                sel_valid;
    logic [PTR_W-1:0]    sel_id;
    logic [INSTR_W-1:0]  sel_instr;
    logic                issue_hs;

    logic                res_in_range;
    logic [PTR_W-1:0]    res_idx;

    // A core may be picked only while it requests and still holds a credit.
    always_comb begin
        for (int k = 0; k < NB_CORES; k++) begin
            eligible[k] = core_valid_i[k] && (cnt_q[k] < CNT_MAX);
        end
    end

    // Round-robin search: first eligible core at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NB_CORES);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign pick_instr = core_instr_i[int'(pick_id)*INSTR_W +: INSTR_W];

    // Selected request: the latched grant while locked, the fresh pick otherwise.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        sel_instr = '0;
        if (state_q == ST_LOCKED) begin
            sel_valid = 1'b1;
            sel_id    = gnt_id_q;
            sel_instr = gnt_instr_q;
        end else if (pick_found) begin
            sel_valid = 1'b1;
            sel_id    = pick_id;
            sel_instr = pick_instr;
        end
    end

    // The fresh pick is combinational from core_valid_i, so the issue outputs
    // are also gated by reset to stay quiet while rst_ni is low.
    assign fpu_valid_o   = rst_ni & sel_valid;
    assign fpu_instr_o   = fpu_valid_o ? sel_instr : '0;
    assign fpu_core_id_o = fpu_valid_o ? 32'(sel_id) : '0;
    assign issue_hs      = fpu_valid_o & fpu_ready_i;

    // Issue accept goes back only to the core whose request is on the bus.
    always_comb begin
        core_ready_o = '0;
        if (issue_hs) begin
            core_ready_o[sel_id] = 1'b1;
        end
    end

    assign res_in_range = (res_core_id_i < 32'(NB_CORES));
    assign res_idx      = res_core_id_i[PTR_W-1:0];

    // Result routing: one-hot valid to the destination core; results for a
    // non-existent core are swallowed so the fpu_ss never stalls on them.
    always_comb begin
        core_res_valid_o = '0;
        res_ready_o      = 1'b1;
        if (res_in_range) begin
            res_ready_o = core_res_ready_i[res_idx];
            if (res_valid_i) begin
                core_res_valid_o[res_idx] = 1'b1;
            end
        end
    end

    // Grant FSM and round-robin pointer next state.
    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        gnt_instr_d = gnt_instr_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !fpu_ready_i) begin
                    state_d     = ST_LOCKED;
                    gnt_id_d    = pick_id;
                    gnt_instr_d = pick_instr;
                end
            end
            ST_LOCKED: begin
                if (fpu_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue_hs) begin
            rr_ptr_d = (int'(sel_id) == NB_CORES - 1) ? '0 : sel_id + PTR_W'(1);
        end
    end

    // Credit counters: +1 on issue, -1 on delivered result, hold on both.
    always_comb begin
        for (int k = 0; k < NB_CORES; k++) begin
            cnt_d[k] = cnt_q[k];
            if (core_ready_o[k] && !(core_res_valid_o[k] && core_res_ready_i[k])) begin
                if (cnt_q[k] < CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end else if (!core_ready_o[k] && core_res_valid_o[k] && core_res_ready_i[k]) begin
                if (cnt_q[k] != '0) begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
    end

    // Control state registers; a reset abandons any held grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            gnt_instr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            gnt_instr_q <= gnt_instr_d;
            err_q       <= res_valid_i & ~res_in_range;
        end
    end

    // Credit counter array registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this array is credit state, not a data store, so it must be
            // reset; leaving it undefined would block or over-admit cores.
            for (int k = 0; k < NB_CORES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB_CORES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Self-checking bench for fpu_ss_core_arbiter (NB_CORES=8, INSTR_W=32,
// MAX_OUTSTANDING=4): a cycle table for round-robin issue and result routing,
// then hand-written sequences for lock, credits, collisions, errors and reset.
module tb_fpu_ss_core_arbiter;

    localparam int NB = 8;
    localparam int IW = 32;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NB-1:0]   core_valid;
    logic [NB-1:0]   core_ready;
    logic [NB*IW-1:0] core_instr;
    logic            fpu_valid;
    logic            fpu_ready;
    logic [IW-1:0]   fpu_instr;
    logic [31:0]     fpu_core_id;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_id;
    logic [NB-1:0]   core_res_valid;
    logic [NB-1:0]   core_res_ready;
    logic            err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_ss_core_arbiter #(
        .NB_CORES(NB), .INSTR_W(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_valid_i(core_valid), .core_ready_o(core_ready), .core_instr_i(core_instr),
        .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_instr_o(fpu_instr),
        .fpu_core_id_o(fpu_core_id),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_core_id_i(res_id),
        .core_res_valid_o(core_res_valid), .core_res_ready_i(core_res_ready),
        .err_o(err)
    );

    typedef struct {
        logic [7:0]  cv;
        logic        fr;
        logic        rv;
        logic [31:0] rid;
        logic [7:0]  crr;
        logic        ev;
        logic [31:0] eid;
        logic [7:0]  ecr;
        logic        erdy;
        logic [7:0]  ecrv;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_valid     = '0;
        fpu_ready      = 1'b0;
        res_valid      = 1'b0;
        res_id         = '0;
        core_res_ready = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Issue-side outputs for a given expected grant (instruction 0x1000+id).
    task automatic check_issue(input string name, input logic ev, input int eid, input logic [7:0] ecr);
        check({name, ".valid"}, 64'(fpu_valid), 64'(ev));
        check({name, ".id"}, 64'(fpu_core_id), ev ? 64'(eid) : 64'd0);
        check({name, ".instr"}, 64'(fpu_instr), ev ? 64'(32'h1000 + eid) : 64'd0);
        check({name, ".core_ready"}, 64'(core_ready), 64'(ecr));
    endtask

    initial begin
        for (int k = 0; k < NB; k++) core_instr[k*IW +: IW] = 32'h1000 + k;

        //          cv     fr    rv    rid    crr     ev    eid  ecr    erdy  ecrv
        vecs[0]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 0, 8'h01, 1'b1, 8'h00};
        vecs[1]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 3, 8'h08, 1'b1, 8'h00};
        vecs[2]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 5, 8'h20, 1'b1, 8'h00};
        vecs[3]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 0, 8'h01, 1'b1, 8'h00};
        vecs[4]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 3, 8'h08, 1'b1, 8'h00};
        vecs[5]  = '{8'h29, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 5, 8'h20, 1'b1, 8'h00};
        vecs[6]  = '{8'h00, 1'b1, 1'b1, 32'd3, 8'h08, 1'b0, 0, 8'h00, 1'b1, 8'h08};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 32'd5, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h20};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 32'd2, 8'h04, 1'b0, 0, 8'h00, 1'b1, 8'h00};
        vecs[9]  = '{8'h28, 1'b0, 1'b0, 32'd0, 8'hFF, 1'b1, 3, 8'h00, 1'b1, 8'h00};
        vecs[10] = '{8'h20, 1'b1, 1'b0, 32'd0, 8'hFF, 1'b1, 3, 8'h08, 1'b1, 8'h00};

        // Reset state with requests and a result present.
        idle_inputs();
        rst_n = 1'b0;
        core_valid = 8'hFF;
        fpu_ready = 1'b1;
        res_valid = 1'b1;
        res_id = 32'd2;
        core_res_ready = 8'h04;
        tick();
        check_issue("rst", 1'b0, 0, 8'h00);
        check("rst.err", 64'(err), 64'd0);
        check("rst.res_valid", 64'(core_res_valid), 64'h04);
        check("rst.res_ready", 64'(res_ready), 64'd1);
        do_reset();

        // Table: round-robin 0,3,5 then result routing, then a lock held across
        // a dropped core_valid.
        for (int i = 0; i < 11; i++) begin
            core_valid     = vecs[i].cv;
            fpu_ready      = vecs[i].fr;
            res_valid      = vecs[i].rv;
            res_id         = vecs[i].rid;
            core_res_ready = vecs[i].crr;
            #1;
            check_issue($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].eid), vecs[i].ecr);
            check($sformatf("vec%0d.res_ready", i), 64'(res_ready), 64'(vecs[i].erdy));
            check($sformatf("vec%0d.res_valid", i), 64'(core_res_valid), 64'(vecs[i].ecrv));
            tick();
        end
        idle_inputs();
        check("tbl.cnt0", 64'(dut.cnt_q[0]), 64'd2);
        check("tbl.cnt3", 64'(dut.cnt_q[3]), 64'd2);
        check("tbl.cnt5", 64'(dut.cnt_q[5]), 64'd2);

        // Held grant: instruction latched at grant time survives a change.
        do_reset();
        core_valid = 8'h04;
        #1;
        check_issue("lock.c1", 1'b1, 2, 8'h00);
        tick();
        core_instr[2*IW +: IW] = 32'hDEAD;
        #1;
        check_issue("lock.c2", 1'b1, 2, 8'h00);
        tick();
        check_issue("lock.c3", 1'b1, 2, 8'h00);
        tick();
        core_valid = 8'h00;
        fpu_ready = 1'b1;
        #1;
        check_issue("lock.c4", 1'b1, 2, 8'h04);
        tick();
        fpu_ready = 1'b0;
        #1;
        check("lock.after_valid", 64'(fpu_valid), 64'd0);
        check("lock.cnt2", 64'(dut.cnt_q[2]), 64'd1);
        core_instr[2*IW +: IW] = 32'h1002;

        // Credit exhaustion on core 1, then recovery after one result.
        do_reset();
        core_valid = 8'h02;
        fpu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_issue($sformatf("cred.issue%0d", i), 1'b1, 1, 8'h02);
            tick();
        end
        check("cred.cnt1_full", 64'(dut.cnt_q[1]), 64'd4);
        #1;
        check("cred.blocked", 64'(fpu_valid), 64'd0);
        core_valid = 8'h12;
        #1;
        check_issue("cred.core4", 1'b1, 4, 8'h10);
        tick();
        core_valid = 8'h00;
        res_valid = 1'b1;
        res_id = 32'd1;
        core_res_ready = 8'h02;
        #1;
        check("cred.res_valid", 64'(core_res_valid), 64'h02);
        tick();
        res_valid = 1'b0;
        check("cred.cnt1", 64'(dut.cnt_q[1]), 64'd3);
        check("cred.cnt4", 64'(dut.cnt_q[4]), 64'd1);
        core_valid = 8'h02;
        #1;
        check_issue("cred.again", 1'b1, 1, 8'h02);
        tick();
        idle_inputs();

        // Simultaneous issue and result for core 6; then decrement and saturation.
        do_reset();
        core_valid = 8'h40;
        fpu_ready = 1'b1;
        tick();
        tick();
        check("both.cnt6_pre", 64'(dut.cnt_q[6]), 64'd2);
        res_valid = 1'b1;
        res_id = 32'd6;
        core_res_ready = 8'h40;
        #1;
        check("both.core_ready", 64'(core_ready), 64'h40);
        check("both.res_valid", 64'(core_res_valid), 64'h40);
        tick();
        check("both.cnt6", 64'(dut.cnt_q[6]), 64'd2);
        core_valid = 8'h00;
        tick();
        check("dec.cnt6", 64'(dut.cnt_q[6]), 64'd1);
        res_id = 32'd0;
        core_res_ready = 8'h01;
        #1;
        check("sat.res_valid", 64'(core_res_valid), 64'h01);
        tick();
        check("sat.cnt0", 64'(dut.cnt_q[0]), 64'd0);
        idle_inputs();

        // Result for a non-existent core.
        do_reset();
        res_valid = 1'b1;
        res_id = 32'd9;
        core_res_ready = 8'hFD;
        #1;
        check("bad.res_ready", 64'(res_ready), 64'd1);
        check("bad.res_valid", 64'(core_res_valid), 64'h00);
        check("bad.err_now", 64'(err), 64'd0);
        tick();
        res_valid = 1'b0;
        check("bad.err_next", 64'(err), 64'd1);
        check("bad.cnt1", 64'(dut.cnt_q[1]), 64'd0);
        tick();
        check("bad.err_gone", 64'(err), 64'd0);

        // Reset asserted while locked on core 7.
        do_reset();
        core_valid = 8'h80;
        #1;
        check_issue("rlk.grant", 1'b1, 7, 8'h00);
        tick();
        #2;
        rst_n = 1'b0;
        fpu_ready = 1'b1;
        #1;
        check_issue("rlk.in_reset", 1'b0, 0, 8'h00);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        check("rlk.valid_after", 64'(fpu_valid), 64'd0);
        check("rlk.rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
        check("rlk.cnt7", 64'(dut.cnt_q[7]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
